// File: rtl/main_mem_responder.sv
// main_mem_responder: line-burst backing store servicing cache refills and writebacks (optional CRITICAL_WORD_FIRST_EN).
module main_mem_responder #(
  parameter int ADDRESS_WIDTH  = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int OFFSET_WIDTH   = 6,
  parameter int MEM_ADDR_WIDTH = 14,
  parameter int READ_LATENCY   = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_write,
  input  logic [ADDRESS_WIDTH-1:0] req_addr,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [DATA_WIDTH-1:0]    wr_data,
  output logic                     rd_valid,
  output logic [DATA_WIDTH-1:0]    rd_data,
  output logic                     rd_last,
  output logic                     wr_done,
  output logic                     busy
);
  localparam int LW = READ_LATENCY > 1 ? $clog2(READ_LATENCY) : 1;
  localparam logic [1:0] IDLE = 2'd0, WR_BURST = 2'd1, RD_WAIT = 2'd2, RD_BURST = 2'd3;
  logic [1:0] state;
  logic [MEM_ADDR_WIDTH-OFFSET_WIDTH-1:0] line;
  logic [OFFSET_WIDTH-1:0] beat, first, start;
  logic [LW-1:0] lat;
  logic [DATA_WIDTH-1:0] mem [2**MEM_ADDR_WIDTH];
  logic [MEM_ADDR_WIDTH-1:0] idx;
  logic accept, wr_fire, rd_fire, beat_end, unused_bits;
`ifdef CRITICAL_WORD_FIRST_EN
  assign start = req_addr[OFFSET_WIDTH-1:0];
`else
  assign start = '0;
`endif
  assign unused_bits = ^{req_addr[ADDRESS_WIDTH-1:MEM_ADDR_WIDTH], req_addr[OFFSET_WIDTH-1:0]};
  assign req_ready = state == IDLE && !reset;
  assign wr_ready = state == WR_BURST && !reset;
  assign busy = state != IDLE && !reset;
  assign accept = req_ready && req_valid;
  assign wr_fire = wr_ready && wr_valid;
  // the final latency cycle already issues beat 0 so the first word lands exactly READ_LATENCY edges after accept
  assign rd_fire = !reset && (state == RD_BURST || (state == RD_WAIT && lat == '0));
  assign beat_end = beat + OFFSET_WIDTH'(1) == first;
  assign idx = {line, beat};
  always_ff @(posedge clk)
    if (wr_fire) mem[idx] <= wr_data;
  always_ff @(posedge clk)
    if (reset) begin
      state    <= IDLE;
      line     <= '0;
      beat     <= '0;
      first    <= '0;
      lat      <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
      rd_last  <= 1'b0;
      wr_done  <= 1'b0;
    end else begin
      rd_valid <= rd_fire;
      rd_last  <= rd_fire && beat_end;
      wr_done  <= wr_fire && beat_end;
      if (rd_fire) rd_data <= mem[idx];
      if (accept) begin
        line  <= req_addr[MEM_ADDR_WIDTH-1:OFFSET_WIDTH];
        beat  <= req_write ? '0 : start;
        first <= req_write ? '0 : start;
        lat   <= LW'(READ_LATENCY - 1);
        state <= req_write ? WR_BURST : RD_WAIT;
      end else if (wr_fire || rd_fire) begin
        beat  <= beat + OFFSET_WIDTH'(1);
        state <= beat_end ? IDLE : rd_fire ? RD_BURST : state;
      end else if (state == RD_WAIT) lat <= lat - LW'(1);
    end
endmodule

// File: tb/tb_main_mem_responder.sv
// tb_main_mem_responder: directed checks of a latency-4 and a latency-1 responder driven in lockstep.
module tb_main_mem_responder;
  logic clk = 1'b0, reset = 1'b1, req_valid = 1'b0, req_write = 1'b0, wr_valid = 1'b0;
  logic [31:0] req_addr = '0, wr_data = '0;
  logic rr0, wrr0, rv0, rl0, wd0, b0, rr1, wrr1, rv1, rl1, wd1, b1;
  logic [31:0] rd0, rd1;
  logic [31:0] mdl [16384];
  logic [31:0] g0 [64];
  logic [31:0] g1 [64];
  int tests = 0, fails = 0;
  int n0, n1, f0, f1, l0, l1;
  typedef struct packed {
    logic rst, rv, rw, wv;
    logic [31:0] addr;
    logic [5:0] exp;
  } vec_t;
  vec_t vec [11];

  always #5 clk = ~clk;

  main_mem_responder dut0 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(rr0), .req_write(req_write),
    .req_addr(req_addr), .wr_valid(wr_valid), .wr_ready(wrr0), .wr_data(wr_data),
    .rd_valid(rv0), .rd_data(rd0), .rd_last(rl0), .wr_done(wd0), .busy(b0)
  );
  main_mem_responder #(.READ_LATENCY(1)) dut1 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(rr1), .req_write(req_write),
    .req_addr(req_addr), .wr_valid(wr_valid), .wr_ready(wrr1), .wr_data(wr_data),
    .rd_valid(rv1), .rd_data(rd1), .rd_last(rl1), .wr_done(wd1), .busy(b1)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic wb(input logic [31:0] a, input logic [31:0] d, input int gap_at, input int abort_at, input logic chain);
    logic ok;
    logic [13:0] base;
    ok = 1'b1;
    base = a[13:0] & 14'h3FC0;
    @(negedge clk);
    chk("wb_req_ready", rr0, 1);
    req_valid = 1'b1; req_write = 1'b1; req_addr = a;
    for (int i = 0; i < 64; i++) begin
      if (i == gap_at)
        repeat (3) begin
          @(negedge clk);
          req_valid = 1'b0; wr_valid = 1'b0;
          if (!wrr0 || wd0 || !b0) ok = 1'b0;
        end
      @(negedge clk);
      req_valid = 1'b0;
      if (!wrr0 || wd0 || !b0) ok = 1'b0;
      wr_valid = 1'b1; wr_data = d + i;
      if (i == abort_at) begin
        reset = 1'b1;
        break;
      end
      mdl[int'(base) + i] = d + i;
    end
    chk("wb_ready_busy", {31'b0, ok}, 1);
    @(negedge clk);
    wr_valid = 1'b0; reset = 1'b0;
    #1;
    chk("wb_done", wd0, abort_at < 0 ? 1 : 0);
    chk("wb_busy_fall", b0, 0);
    chk("wb_idle_ready", rr0, 1);
    if (!chain) begin
      @(negedge clk);
      chk("wb_done_pulse", wd0, 0);
    end
  endtask

  task automatic collect;
    n0 = 0; n1 = 0; f0 = -1; f1 = -1; l0 = -1; l1 = -1;
    for (int k = 0; k < 200 && (n0 < 64 || n1 < 64); k++) begin
      @(negedge clk);
      req_valid = 1'b0;
      if (rv0) begin
        if (f0 < 0) f0 = k;
        if (rl0) l0 = n0;
        if (n0 < 64) g0[n0] = rd0;
        n0++;
      end
      if (rv1) begin
        if (f1 < 0) f1 = k;
        if (rl1) l1 = n1;
        if (n1 < 64) g1[n1] = rd1;
        n1++;
      end
    end
  endtask

  task automatic refill(input logic [31:0] a, input logic chained, input string nm);
    int s, e0, e1;
    logic [13:0] base;
    logic [31:0] exp;
    if (!chained) @(negedge clk);
    chk($sformatf("%s_req_ready", nm), rr0, 1);
    req_valid = 1'b1; req_write = 1'b0; req_addr = a;
    collect;
    base = a[13:0] & 14'h3FC0;
`ifdef CRITICAL_WORD_FIRST_EN
    s = int'(a[5:0]);
`else
    s = 0;
`endif
    e0 = 0; e1 = 0;
    for (int j = 0; j < 64; j++) begin
      exp = mdl[int'(base) + ((s + j) % 64)];
      if (g0[j] !== exp) begin
        if (e0 == 0) $display("FAIL %s_word0[%0d]: got %h expected %h", nm, j, g0[j], exp);
        e0++;
      end
      if (g1[j] !== exp) e1++;
    end
    chk($sformatf("%s_bad_words", nm), e0, 0);
    chk($sformatf("%s_bad_words_lat1", nm), e1, 0);
    chk($sformatf("%s_count", nm), n0, 64);
    chk($sformatf("%s_count_lat1", nm), n1, 64);
    chk($sformatf("%s_latency", nm), f0, 4);
    chk($sformatf("%s_latency_lat1", nm), f1, 1);
    chk($sformatf("%s_last_pos", nm), l0, 63);
    chk($sformatf("%s_last_pos_lat1", nm), l1, 63);
    @(negedge clk);
    chk($sformatf("%s_valid_drop", nm), {30'b0, rv0, rv1}, 0);
  endtask

  initial begin
    vec[0]  = {1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        6'b000000};
    vec[1]  = {1'b0, 1'b0, 1'b0, 1'b1, 32'h0,        6'b100000};
    vec[2]  = {1'b0, 1'b1, 1'b0, 1'b0, 32'hFFFFFFC3, 6'b100000};
    vec[3]  = {1'b0, 1'b1, 1'b0, 1'b1, 32'h0,        6'b001000};
    vec[4]  = {1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        6'b001001};
    vec[5]  = {1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        6'b001001};
    vec[6]  = {1'b0, 1'b1, 1'b0, 1'b1, 32'h0,        6'b001001};
    vec[7]  = {1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        6'b001101};
    vec[8]  = {1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        6'b000101};
    vec[9]  = {1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        6'b100000};
    vec[10] = {1'b0, 1'b0, 1'b0, 1'b1, 32'h0,        6'b100000};
    repeat (2) @(negedge clk);
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      reset = vec[i].rst; req_valid = vec[i].rv; req_write = vec[i].rw;
      wr_valid = vec[i].wv; req_addr = vec[i].addr;
      #1;
      chk($sformatf("vec%0d_rr_wr_busy_rv_done_rv1", i), {26'b0, rr0, wrr0, b0, rv0, wd0, rv1}, {26'b0, vec[i].exp});
    end
    @(negedge clk);
    req_valid = 1'b0; wr_valid = 1'b0; req_write = 1'b0;
    wb(32'h0000_004A, 32'hA000_0000, 11, -1, 1'b0);
    repeat (3) begin
      @(negedge clk);
      wr_valid = 1'b1; wr_data = 32'hDEAD_BEEF;
      chk("idle_wr_ready", wrr0, 0);
    end
    @(negedge clk);
    wr_valid = 1'b0;
    refill(32'h0000_0045, 1'b0, "rf_a");
    wb(32'h0000_0080, 32'hD000_0000, -1, -1, 1'b1);
    refill(32'h0000_0083, 1'b1, "rf_chain");
    wb(32'h0000_3FC0, 32'hC000_0000, -1, -1, 1'b0);
    refill(32'hFFFF_FFC3, 1'b0, "rf_top");
    wb(32'h0000_0040, 32'hB000_0000, -1, 20, 1'b0);
    refill(32'h0000_0045, 1'b0, "rf_abort");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/main_mem_responder.md
Name: main_mem_responder

Overview:
- Main-memory side of the cache refill/writeback interface: services line-sized burst requests from the set-associative cache.
- Holds a word-addressed backing store.
- Accepts dirty-line writebacks word by word and returns refill lines after a fixed access latency, one word per cycle, so the cache can write each beat straight into the selected way.

Parameters:
ADDRESS_WIDTH, 32, width of the request address (byte-free word address, same format as the cache mem_add)
DATA_WIDTH, 32, width of one word
OFFSET_WIDTH, 6, word-offset bits per line; WORDS_PER_BLOCK = 2**OFFSET_WIDTH
MEM_ADDR_WIDTH, 14, backing-store word-index width; depth = 2**MEM_ADDR_WIDTH words
READ_LATENCY, 4, cycles from refill-request accept to first rd_valid; legal range >= 1

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous active-high reset
req_valid  in  1  line request present
req_ready  out  1  responder can accept a request
req_write  in  1  1 = writeback burst, 0 = refill burst
req_addr  in  ADDRESS_WIDTH  any word address inside the target line
wr_valid  in  1  writeback word present on wr_data
wr_ready  out  1  responder accepts writeback word
wr_data  in  DATA_WIDTH  writeback word
rd_valid  out  1  refill word valid on rd_data
rd_data  out  DATA_WIDTH  refill word
rd_last  out  1  marks final refill word of the line
wr_done  out  1  one-cycle pulse: writeback line fully committed
busy  out  1  high whenever state != IDLE

Behaviour:
- Interface timing: one clock (clk); reset is synchronous and active-high (reset), sampled only on the rising edge of clk.
- Address decode:
  - Word index = req_addr[MEM_ADDR_WIDTH-1:0]; upper address bits ignored (aliasing is permitted).
  - Line base = word index with the low OFFSET_WIDTH bits forced to 0.
- Backing store: not cleared by reset; contents undefined until written.
- States:
  - IDLE: req_ready=1. On req_valid, latch the line base and go to WR_BURST (req_write=1) or RD_WAIT (req_write=0). Load latency counter = READ_LATENCY-1 and beat counter = 0.
  - WR_BURST: wr_ready=1.
    - Each cycle with wr_valid=1 writes wr_data to base+beat and increments beat.
    - wr_valid gaps are allowed and hold the counter.
    - On the beat equal to WORDS_PER_BLOCK-1, go to IDLE and pulse wr_done in the first IDLE cycle.
  - RD_WAIT: decrement latency counter; at 0, go to RD_BURST. First rd_valid appears exactly READ_LATENCY cycles after the accept edge.
  - RD_BURST:
    - rd_valid=1 every cycle with no backpressure.
    - rd_data = store[base + beat (mod WORDS_PER_BLOCK)], registered.
    - rd_last=1 on the final beat; then go to IDLE.
- Outputs are registered. req_ready and wr_ready are decoded from state.
- Reset values: req_ready=0 during the reset cycle, then 1 in IDLE. wr_ready=0, rd_valid=0, rd_data=0, rd_last=0, wr_done=0, busy=0.
- Handshake rules:
  - req_valid, wr_valid, req_write, req_addr and wr_data are ignored in any state where the matching ready is 0.
  - wr_valid in IDLE or RD_* is dropped.
- Back-to-back requests: the wr_done pulse cycle is IDLE with req_ready=1, so a new request may be accepted in the same cycle.
- Read-after-writeback: a refill of the same line requested after wr_done returns the newly written words.
- Wrap-around:
  - Beat counter is OFFSET_WIDTH bits and wraps naturally.
  - Line base + beat never crosses the line boundary.
  - The top line (base = 2**MEM_ADDR_WIDTH - WORDS_PER_BLOCK) is legal.
- Reset mid-burst: return to IDLE and clear all outputs. Writeback words already committed remain in the store. No wr_done is issued for the aborted burst. An aborted refill emits no further rd_valid.

Optional Feature:
- Macro: CRITICAL_WORD_FIRST_EN
- Defined:
  - Refill burst starts at the requested offset req_addr[OFFSET_WIDTH-1:0] and wraps modulo WORDS_PER_BLOCK within the line.
  - rd_last is on the word before the requested offset (offset-1 mod WORDS_PER_BLOCK).
  - Writeback always starts at offset 0.
- Not defined: refill always starts at offset 0 and the req_addr offset bits are ignored.

Test Plan:
- Reset, then idle: req_ready=1, busy=0, all other outputs 0; wr_valid pulses in IDLE cause no store write.
- Writeback to line 0x0040 with data 0xA000_0000+i, with a 3-cycle wr_valid gap after beat 10 -> wr_ready=1 throughout, wr_done pulses once after 64 accepted beats, busy falls in the same cycle.
- Refill of the same line, req_addr=0x0045 -> first rd_valid 4 cycles after accept; 64 consecutive words 0xA000_0000..0xA000_003F; rd_last on the 64th.
  - With CRITICAL_WORD_FIRST_EN: order is 0xA000_0005..3F, then 00..04; rd_last on 0xA000_0004.
- Writeback immediately followed by a refill request asserted during the wr_done cycle -> request accepted that cycle, refill returns the new data with no stale words.
- Reset asserted at writeback beat 20, then a refill of that line -> beats 0..19 hold new data, 20..63 hold prior contents, no wr_done.
- READ_LATENCY=1 build: first rd_valid in the cycle after accept; top line (base 0x3FC0) refill returns its words with no index overflow.
